// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings and defaults for the multiply/divide unit
// Purpose: op codes, FSM state encoding and default operand width used by
//          md_unit and div_core.
package md_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - radix-2 restoring divider datapath, one step per cycle
// Purpose: unsigned WIDTH/WIDTH restoring division over WIDTH iterations.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load            latch dividend/divisor and begin iterating
//   abort           drop any division in progress
//   dividend        unsigned dividend (sampled on load)
//   divisor         unsigned nonzero divisor (sampled on load)
//   quotient        quotient after the step taken this cycle
//   remainder       remainder after the step taken this cycle
//   last            this cycle performs the final iteration
module div_core
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;  // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] r_dvs;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // The partial remainder stays below the divisor, so the shifted value
  // needs only one extra bit; its borrow tells whether the divisor fits.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_fits    = ~w_diff[WIDTH];
  assign w_rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};

  assign quotient  = w_quo_nxt;
  assign remainder = w_rem_nxt;
  assign last      = r_busy && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
    end else if (abort) begin
      r_busy <= 1'b0;
    end else if (load) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= dividend;
      r_dvs  <= divisor;
    end else if (r_busy) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide unit with architectural HI/LO registers
// Purpose: single-cycle MULT/MULTU/MTHI/MTLO, multi-cycle DIV/DIVU with
//          pipeline stall, cancel on flush.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start, op       valid md instruction in EX and its operation code
//   opa, opb        rs / rt operands
//   cancel          pipeline flush, aborts a divide
//   stall           hold IF/ID/EX
//   hi_o, lo_o      HI / LO registers
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  output logic             stall,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_e        r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_accept;
  logic             w_is_div;
  logic             w_signed_div;
  logic             w_signed_mul;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div_load;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic             w_last;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_accept     = (r_state == ST_IDLE) && start && !cancel;
  assign w_is_div     = (op == MD_DIV) || (op == MD_DIVU);
  assign w_signed_div = (op == MD_DIV);
  assign w_signed_mul = (op == MD_MULT);
  assign stall        = (w_accept && w_is_div) || (r_state == ST_RUN);

  assign w_abs_a    = (w_signed_div && opa[WIDTH-1]) ? -opa : opa;
  assign w_abs_b    = (w_signed_div && opb[WIDTH-1]) ? -opb : opb;
  assign w_div_load = w_accept && w_is_div && (opb != '0);

  // Extending both operands to 2*WIDTH and keeping the low half of the
  // product gives the exact signed or unsigned result with one multiplier.
  assign w_ext_a = {{WIDTH{w_signed_mul & opa[WIDTH-1]}}, opa};
  assign w_ext_b = {{WIDTH{w_signed_mul & opb[WIDTH-1]}}, opb};
  assign w_prod  = w_ext_a * w_ext_b;

  // Magnitudes are divided; the most-negative dividend wraps back to itself
  // on negation, which yields the architecturally expected result.
  assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
  assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (w_div_load),
    .abort     (cancel),
    .dividend  (w_abs_a),
    .divisor   (w_abs_b),
    .quotient  (w_quo),
    .remainder (w_rem),
    .last      (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !cancel) begin
            case (op)
              MD_MULT, MD_MULTU: {r_hi, r_lo} <= w_prod;
              MD_MTHI: r_hi <= opa;
              MD_MTLO: r_lo <= opa;
              MD_DIV, MD_DIVU: begin
                if (opb == '0) begin
                  r_hi    <= opa;
                  r_lo    <= '1;
                  r_state <= ST_DONE;
                end else begin
                  r_neg_q <= w_signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                  r_neg_r <= w_signed_div && opa[WIDTH-1];
                  r_state <= ST_RUN;
                end
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cancel) begin
            r_state <= ST_IDLE;
          end else if (w_last) begin
            r_lo    <= w_quo_fix;
            r_hi    <= w_rem_fix;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule
